pixel_stream_source: RTL and testbench
======================================

// Module: pixel_stream_source
// PURPOSE
//  Frame-based pixel producer. Drives the upstream side of the 8-bit valid/ready
//  pixel stream consumed by the data processing block.
//  On a start pulse it emits one IMG_W x IMG_H frame of generated test-pattern
//  pixels, with start-of-frame and end-of-line markers.
//  Honours backpressure and inserts optional idle gaps between lines.
// PARAMETERS
//  IMG_W     32  pixels per line (>=2)
//  IMG_H     32  lines per frame (>=1)
//  LINE_GAP  2   idle cycles (out_valid=0) between lines; 0 = back-to-back
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  reset, asynchronous, active-low
//  start       in   1  frame request pulse; sampled only in IDLE
//  pattern     in   2  00 h-ramp, 01 v-ramp, 10 checkerboard, 11 LFSR
//  seed        in   8  ramp offset / LFSR seed
//  out_data    out  8  pixel value
//  out_valid   out  1  out_data, out_sof and out_eol are valid
//  out_ready   in   1  consumer accepts the beat this cycle
//  out_sof     out  1  first pixel of frame (x=0, y=0)
//  out_eol     out  1  last pixel of line (x=IMG_W-1)
//  busy        out  1  high in STREAM and GAP
//  frame_done  out  1  one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: out_data=0, out_valid=0, out_sof=0, out_eol=0, busy=0,
//    frame_done=0, x=0, y=0, lfsr=8'h01, state=IDLE.
//  - Handshake: a beat transfers on a clock edge where out_valid && out_ready.
//  - Once out_valid is asserted it stays high, and out_data, out_sof and out_eol
//    stay stable, until the beat transfers. No beat is dropped or duplicated.
//  - out_valid may assert independently of out_ready; there is no combinational
//    path from out_ready to any output.
//  - State IDLE: out_valid=0.
//    - start=1: latch pattern and seed; x=0, y=0.
//    - lfsr = seed, or 8'h01 when seed=0.
//    - Go to STREAM. The first beat is valid on the cycle after start is sampled
//      (1-cycle latency).
//  - State STREAM: out_valid=1.
//    - On each transfer, x increments and the next pixel is presented on the
//      following cycle. This allows back-to-back beats at 1 pixel/clk.
//    - Transfer with x=IMG_W-1 and y=IMG_H-1: go to DONE.
//    - Transfer with x=IMG_W-1 and y<IMG_H-1: x=0, y++, then go to GAP if
//      LINE_GAP>0, else stay in STREAM.
//  - State GAP: out_valid=0 for exactly LINE_GAP cycles, then return to STREAM.
//  - State DONE: frame_done=1 for one cycle, out_valid=0, busy=0, then IDLE.
//  - start outside IDLE is ignored. pattern and seed changes mid-frame are ignored.
//  - Pixel functions, all arithmetic mod 256, using x[7:0] and y[7:0]:
//    - 00: seed + x
//    - 01: seed + y
//    - 10: (x[3]^y[3]) ? 8'hFF : 8'h00
//    - 11: current lfsr value. Fibonacci LFSR: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//      Advances on each transfer only; it does not reset per line.
//  - out_sof is high only on the beat x=0, y=0. out_eol is high on every x=IMG_W-1 beat.
//  - Reset mid-frame: everything clears immediately to reset values. No partial
//    frame resumes; the next start begins a fresh frame.
//  - Counter width: $clog2(IMG_W) for x, $clog2(IMG_H) for y. No wrap within a frame.
// TESTING
//  1. IMG_W=4, IMG_H=2, LINE_GAP=0, pattern=00, seed=10, out_ready=1, pulse start:
//     - beats 10,11,12,13,10,11,12,13, back-to-back
//     - sof on beat 1 only; eol on beats 4 and 8
//     - frame_done on the cycle after the last transfer
//  2. Test 1 setup with out_ready held low for 5 cycles while beat 2 is presented:
//     - out_valid stays 1, out_data holds 11 throughout
//     - total of 8 beats, none lost or repeated
//  3. LINE_GAP=2, IMG_W=4, IMG_H=2:
//     - out_valid low for exactly 2 cycles between beat 4 and beat 5
//     - busy stays 1 throughout
//  4. pattern=11, seed=0, out_ready=1: first five beats 01,02,04,08,11 (hex).
//  5. Pulse start again during the frame: ignored, frame length unchanged.
//     Assert rst_n=0 at beat 3: all outputs 0 the same cycle. Start again: first
//     beat has sof=1 and value seed.
//  6. IMG_W=32, pattern=10, line y=0: x=0..7 -> 00, x=8..15 -> FF, x=16..23 -> 00.

Source files
------------

// File: rtl/pixel_stream_source.sv
// pixel_stream_source: emits one IMG_W x IMG_H test-pattern frame per start
// request on an 8-bit valid/ready stream, with SOF/EOL markers and optional
// idle gaps between lines. All outputs come straight from flops.
module pixel_stream_source #(
  parameter int unsigned IMG_W    = 32,
  parameter int unsigned IMG_H    = 32,
  parameter int unsigned LINE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] pattern,
  input  logic [7:0] seed,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [GW-1:0] G_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [1:0]    pattern_q, pattern_d;
  logic [7:0]    seed_q, seed_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eol_q, out_eol_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          xfer;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] pixel(input logic [1:0] pat, input logic [7:0] sd,
                                       input logic [7:0] x8, input logic [7:0] y8,
                                       input logic [7:0] lf);
    logic [7:0] p;
    case (pat)
      2'b00:   p = sd + x8;
      2'b01:   p = sd + y8;
      2'b10:   p = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
      default: p = lf;
    endcase
    return p;
  endfunction

  // Next-state, counters and the next registered output beat.
  // The pixel for the following beat is computed from the post-transfer
  // x/y/lfsr values so that a new beat appears the cycle after each transfer.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    gap_d        = gap_q;
    lfsr_d       = lfsr_q;
    pattern_d    = pattern_q;
    seed_d       = seed_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_sof_d    = out_sof_q;
    out_eol_d    = out_eol_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    xfer         = out_valid_q && out_ready;

    case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          pattern_d   = pattern;
          seed_d      = seed;
          x_d         = '0;
          y_d         = '0;
          lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
          state_d     = S_STREAM;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_data_d  = pixel(pattern, seed, 8'h00, 8'h00, lfsr_d);
          out_sof_d   = 1'b1;
          out_eol_d   = 1'b0;
        end
      end

      S_STREAM: begin
        if (xfer) begin
          lfsr_d = lfsr_next(lfsr_q);
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              state_d      = S_DONE;
              out_valid_d  = 1'b0;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
            end else begin
              x_d = '0;
              y_d = y_q + YW'(1);
              if (LINE_GAP > 0) begin
                state_d     = S_GAP;
                out_valid_d = 1'b0;
                gap_d       = '0;
              end
            end
          end else begin
            x_d = x_q + XW'(1);
          end
          out_data_d = pixel(pattern_q, seed_q, 8'(x_d), 8'(y_d), lfsr_d);
          out_sof_d  = 1'b0;
          out_eol_d  = (state_d != S_DONE) && (x_d == X_LAST);
        end
      end

      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == G_LAST) begin
          state_d     = S_STREAM;
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      gap_q        <= '0;
      lfsr_q       <= 8'h01;
      pattern_q    <= '0;
      seed_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gap_q        <= gap_d;
      lfsr_q       <= lfsr_d;
      pattern_q    <= pattern_d;
      seed_q       <= seed_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source: three instances (4x2 no gap,
// 4x2 with 2-cycle gap, 32x2 no gap) driven from a per-cycle vector table
// plus hand sequences for start-ignore, mid-frame reset and checkerboard.
module tb_pixel_stream_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st;
  logic [1:0] pattern;
  logic [7:0] seed;
  logic       ready;

  logic [7:0] od [3];
  logic       ov [3];
  logic       osof [3];
  logic       oeol [3];
  logic       obusy [3];
  logic       ofd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_stream_source #(.IMG_W(4), .IMG_H(2), .LINE_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .pattern(pattern), .seed(seed),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(ready), .out_sof(osof[0]),
    .out_eol(oeol[0]), .busy(obusy[0]), .frame_done(ofd[0]));

  pixel_stream_source #(.IMG_W(4), .IMG_H(2), .LINE_GAP(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .pattern(pattern), .seed(seed),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(ready), .out_sof(osof[1]),
    .out_eol(oeol[1]), .busy(obusy[1]), .frame_done(ofd[1]));

  pixel_stream_source #(.IMG_W(32), .IMG_H(2), .LINE_GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .pattern(pattern), .seed(seed),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(ready), .out_sof(osof[2]),
    .out_eol(oeol[2]), .busy(obusy[2]), .frame_done(ofd[2]));

  typedef struct {
    bit         go;
    int         sel;
    logic [1:0] pat;
    logic [7:0] sd;
    bit         rdy;
    bit         v;
    logic [7:0] d;
    bit         sof;
    bit         eol;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t r(bit go, int sel, logic [1:0] pat, logic [7:0] sd, bit rdy,
                             bit v, logic [7:0] d, bit sof, bit eol, bit bsy, bit done);
    vec_t t;
    t.go = go; t.sel = sel; t.pat = pat; t.sd = sd; t.rdy = rdy;
    t.v = v; t.d = d; t.sof = sof; t.eol = eol; t.busy = bsy; t.done = done;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input int s);
    @(posedge clk); #1;
    st[s] = 1'b1;
    @(posedge clk); #1;
    st[s] = 1'b0;
  endtask

  // Four-beat lines (a,b,c,d then e,f,g,h) on dut0 with ready held high.
  task automatic add_frame8(input logic [1:0] pat, input logic [7:0] sd,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] e, input logic [7:0] f,
                            input logic [7:0] g, input logic [7:0] h);
    tbl.push_back(r(1, 0, pat, sd, 1, 1, a, 1, 0, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, b, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, c, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, d, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, e, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, f, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, g, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 1, h, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, pat, sd, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 0, pat, sd, 1, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0; st = '0; pattern = '0; seed = '0; ready = 1'b0;

    // Basic h-ramp, v-ramp wrap, h-ramp wrap, LFSR from seed 0.
    add_frame8(2'b00, 8'd10, 10, 11, 12, 13, 10, 11, 12, 13);
    add_frame8(2'b01, 8'd255, 255, 255, 255, 255, 0, 0, 0, 0);
    add_frame8(2'b00, 8'd254, 254, 255, 0, 1, 254, 255, 0, 1);
    add_frame8(2'b11, 8'd0, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E);
    // Backpressure: beat 2 held for 5 stalled cycles.
    tbl.push_back(r(1, 0, 0, 10, 1, 1, 10, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(r(0, 0, 0, 10, 0, 1, 11, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 11, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 12, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 13, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 10, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 11, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 12, 0, 0, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 1, 13, 0, 1, 1, 0));
    tbl.push_back(r(0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0));
    // Line gap of 2 on dut1: valid low two cycles, busy held.
    tbl.push_back(r(1, 1, 0, 10, 1, 1, 10, 1, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 11, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 12, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 13, 0, 1, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 10, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 11, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 12, 0, 0, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 1, 13, 0, 1, 1, 0));
    tbl.push_back(r(0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(r(0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0));

    // Reset state of all instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.valid", k), 32'(ov[k]), 0);
      chk($sformatf("rst%0d.data", k), 32'(od[k]), 0);
      chk($sformatf("rst%0d.sof", k), 32'(osof[k]), 0);
      chk($sformatf("rst%0d.eol", k), 32'(oeol[k]), 0);
      chk($sformatf("rst%0d.busy", k), 32'(obusy[k]), 0);
      chk($sformatf("rst%0d.done", k), 32'(ofd[k]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven per-cycle vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      int s;
      s = tbl[i].sel;
      if (tbl[i].go) begin
        pattern = tbl[i].pat;
        seed    = tbl[i].sd;
        pulse_start(s);
      end
      ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d.valid", i), 32'(ov[s]), 32'(tbl[i].v));
      chk($sformatf("vec%0d.busy", i), 32'(obusy[s]), 32'(tbl[i].busy));
      chk($sformatf("vec%0d.done", i), 32'(ofd[s]), 32'(tbl[i].done));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d.data", i), 32'(od[s]), 32'(tbl[i].d));
        chk($sformatf("vec%0d.sof", i), 32'(osof[s]), 32'(tbl[i].sof));
        chk($sformatf("vec%0d.eol", i), 32'(oeol[s]), 32'(tbl[i].eol));
      end
      @(posedge clk); #1;
    end

    // Start pulses mid-frame are ignored; frame keeps 8 beats.
    pattern = 2'b00; seed = 8'd5; ready = 1'b1;
    pulse_start(0);
    n = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      st[0] = (c == 1 || c == 2);
      @(negedge clk);
      if (ov[0]) n++;
      if (ofd[0]) seen = 1;
      @(posedge clk); #1;
    end
    st[0] = 1'b0;
    chk("ignore_start.beats", 32'(n), 8);
    chk("ignore_start.done_seen", 32'(seen), 1);
    @(negedge clk);
    chk("ignore_start.no_restart", 32'(ov[0]), 0);
    @(posedge clk); #1;

    // Asynchronous reset while beat 3 is presented, then a fresh frame.
    pulse_start(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.beat3_valid", 32'(ov[0]), 1);
    chk("midrst.beat3_data", 32'(od[0]), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(ov[0]), 0);
    chk("midrst.data", 32'(od[0]), 0);
    chk("midrst.busy", 32'(obusy[0]), 0);
    chk("midrst.sof", 32'(osof[0]), 0);
    chk("midrst.eol", 32'(oeol[0]), 0);
    chk("midrst.done", 32'(ofd[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seed = 8'd9;
    pulse_start(0);
    @(negedge clk);
    chk("restart.valid", 32'(ov[0]), 1);
    chk("restart.data", 32'(od[0]), 9);
    chk("restart.sof", 32'(osof[0]), 1);
    chk("restart.busy", 32'(obusy[0]), 1);
    @(posedge clk); #1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ofd[0]) seen = 1;
      @(posedge clk); #1;
    end
    chk("restart.done_seen", 32'(seen), 1);

    // 32-wide checkerboard, first line.
    pattern = 2'b10; seed = 8'h5A;
    pulse_start(2);
    for (int x = 0; x < 32; x++) begin
      @(negedge clk);
      chk($sformatf("cb.x%0d.valid", x), 32'(ov[2]), 1);
      chk($sformatf("cb.x%0d.data", x), 32'(od[2]), ((x / 8) % 2 == 1) ? 32'hFF : 32'h00);
      chk($sformatf("cb.x%0d.sof", x), 32'(osof[2]), (x == 0) ? 1 : 0);
      chk($sformatf("cb.x%0d.eol", x), 32'(oeol[2]), (x == 31) ? 1 : 0);
      @(posedge clk); #1;
    end
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (ofd[2]) seen = 1;
      @(posedge clk); #1;
    end
    chk("cb.done_seen", 32'(seen), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
